// File: rtl/spi_frame_receiver.sv
// -----------------------------------------------------------------------------
// spi_frame_receiver
//
// SPI-side ingress stage of the video path. It runs entirely in the SPI clock
// domain (write_clk). While cs_n is low it deserialises MOSI, MSB first, and
// waits for a sync byte. After a match it packs the following
// FRAME_W*FRAME_H pixel bits into DWIDTH-bit words and writes them into the
// frame FIFO. It also reports frame boundaries, a frame counter and two
// sticky error flags.
//
// Ports
//   write_clk      in   1       SPI clock; cs_n / mosi sampled on posedge
//   reset          in   1       synchronous, active-high
//   cs_n           in   1       chip select, active-low
//   mosi           in   1       serial data, MSB first
//   fifo_full      in   1       FIFO full flag
//   fifo_din       out  DWIDTH  word to FIFO (holds value between strobes)
//   fifo_write_en  out  1       one-cycle write strobe
//   frame_start    out  1       one-cycle pulse after the sync byte matched
//   frame_done     out  1       one-cycle pulse with the frame's last strobe
//   frame_count    out  8       completed frames, wraps 255 -> 0
//   frame_err      out  1       sticky: bad sync byte or frame cut by cs_n
//   overflow       out  1       sticky: word dropped because fifo_full
// -----------------------------------------------------------------------------
module spi_frame_receiver #(
  parameter int         DWIDTH    = 1,
  parameter int         FRAME_W   = 160,
  parameter int         FRAME_H   = 120,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              write_clk,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              mosi,
  input  logic              fifo_full,
  output logic [DWIDTH-1:0] fifo_din,
  output logic              fifo_write_en,
  output logic              frame_start,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic              frame_err,
  output logic              overflow
);

  localparam int WORDS = (FRAME_W * FRAME_H) / DWIDTH;
  localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  // One bit counter serves both the 8-bit header and the DWIDTH-bit words.
  localparam int BCW   = (DWIDTH > 8) ? $clog2(DWIDTH) + 1 : 4;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    PAYLOAD,
    ERR_WAIT
  } state_t;

  state_t            state;
  logic [BCW-1:0]    bit_cnt;
  logic [WCW-1:0]    word_cnt;
  logic [7:0]        hdr_shift;
  logic [DWIDTH-1:0] word_shift;

  // Values after shifting in the current mosi bit. They are used on the edge
  // that captures the final bit, so the comparison and the emitted word
  // already include that bit.
  logic [7:0]        hdr_next;
  logic [DWIDTH-1:0] word_next;
  logic              hdr_last_bit;
  logic              word_last_bit;
  logic              last_word;

  always_comb begin
    // NOTE: every signal gets a value on every path through always_comb, so
    // no latches are inferred.
    hdr_next      = {hdr_shift[6:0], mosi};
    // The cast keeps the low DWIDTH bits, which also covers DWIDTH == 1.
    word_next     = DWIDTH'({word_shift, mosi});
    hdr_last_bit  = (bit_cnt == BCW'(7));
    word_last_bit = (bit_cnt == BCW'(DWIDTH - 1));
    last_word     = (word_cnt == WCW'(WORDS - 1));
  end

  // NOTE: all state lives in this one clocked block and uses non-blocking
  // assignments only. Each register then updates from its pre-edge value,
  // whatever order the statements are written in.
  always_ff @(posedge write_clk) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      word_cnt      <= '0;
      hdr_shift     <= '0;
      word_shift    <= '0;
      fifo_din      <= '0;
      fifo_write_en <= 1'b0;
      frame_start   <= 1'b0;
      frame_done    <= 1'b0;
      frame_count   <= '0;
      frame_err     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      // Pulse outputs default low and are raised only for the cycle after
      // the edge that causes them.
      fifo_write_en <= 1'b0;
      frame_start   <= 1'b0;
      frame_done    <= 1'b0;

      if (cs_n) begin
        // Deselect drops any partial header or word. Losing select in the
        // middle of a frame is an error.
        if (state == PAYLOAD) frame_err <= 1'b1;
        state      <= IDLE;
        bit_cnt    <= '0;
        hdr_shift  <= '0;
        word_shift <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            // The first selected edge already carries header bit 7.
            hdr_shift <= {7'b0, mosi};
            bit_cnt   <= BCW'(1);
            state     <= HUNT;
          end

          HUNT: begin
            hdr_shift <= hdr_next;
            if (hdr_last_bit) begin
              bit_cnt <= '0;
              if (hdr_next == SYNC_BYTE) begin
                state       <= PAYLOAD;
                frame_start <= 1'b1;
                word_cnt    <= '0;
              end else begin
                // Resync is allowed only after the next cs_n deassertion.
                state     <= ERR_WAIT;
                frame_err <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end

          PAYLOAD: begin
            if (word_last_bit) begin
              bit_cnt    <= '0;
              word_shift <= '0;
              if (!fifo_full) begin
                fifo_din      <= word_next;
                fifo_write_en <= 1'b1;
              end else begin
                overflow <= 1'b1;
              end
              // The frame position advances even when a word is dropped, so
              // the frame boundary stays aligned with the host.
              if (last_word) begin
                frame_done  <= 1'b1;
                frame_count <= frame_count + 8'd1;
                word_cnt    <= '0;
                hdr_shift   <= '0;
                state       <= HUNT;
              end else begin
                word_cnt <= word_cnt + WCW'(1);
              end
            end else begin
              word_shift <= word_next;
              bit_cnt    <= bit_cnt + BCW'(1);
            end
          end

          ERR_WAIT: begin
            // mosi is ignored until cs_n goes high.
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_receiver
//
// Directed bench for spi_frame_receiver, configured with DWIDTH=4, FRAME_W=4
// and FRAME_H=2, which gives 2 words per frame. Inputs change on the falling
// edge. A monitor samples the outputs on the falling edge as well, so each
// one-cycle pulse is seen exactly once. Expected words are written by hand.
// -----------------------------------------------------------------------------
module tb_spi_frame_receiver;

  localparam int DW = 4;

  logic          write_clk = 1'b0;
  logic          reset     = 1'b1;
  logic          cs_n      = 1'b1;
  logic          mosi      = 1'b0;
  logic          fifo_full = 1'b0;
  logic [DW-1:0] fifo_din;
  logic          fifo_write_en;
  logic          frame_start;
  logic          frame_done;
  logic [7:0]    frame_count;
  logic          frame_err;
  logic          overflow;

  spi_frame_receiver #(
    .DWIDTH   (DW),
    .FRAME_W  (4),
    .FRAME_H  (2),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .write_clk    (write_clk),
    .reset        (reset),
    .cs_n         (cs_n),
    .mosi         (mosi),
    .fifo_full    (fifo_full),
    .fifo_din     (fifo_din),
    .fifo_write_en(fifo_write_en),
    .frame_start  (frame_start),
    .frame_done   (frame_done),
    .frame_count  (frame_count),
    .frame_err    (frame_err),
    .overflow     (overflow)
  );

  always #5 write_clk = ~write_clk;

  // ---------------------------------------------------------------- monitor
  int            n_strobe   = 0;
  int            n_done     = 0;
  int            n_done_alone = 0;  // frame_done with no strobe in the same cycle
  int            n_start    = 0;
  logic [DW-1:0] words[$];

  always @(negedge write_clk) begin
    if (fifo_write_en) begin
      n_strobe = n_strobe + 1;
      words.push_back(fifo_din);
    end
    if (frame_done) begin
      n_done = n_done + 1;
      if (!fifo_write_en) n_done_alone = n_done_alone + 1;
    end
    if (frame_start) n_start = n_start + 1;
  end

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Baselines so that each test looks only at its own monitor events.
  int b_strobe, b_done, b_alone, b_start, b_q;

  task automatic mark();
    b_strobe = n_strobe;
    b_done   = n_done;
    b_alone  = n_done_alone;
    b_start  = n_start;
    b_q      = words.size();
  endtask

  function automatic logic [31:0] word_at(input int idx);
    if (idx < words.size()) return 32'(words[idx]);
    return 32'hDEAD_BEEF;
  endfunction

  // ---------------------------------------------------------------- stimulus
  task automatic send_bit(input logic c, input logic b, input logic full = 1'b0);
    @(negedge write_clk);
    cs_n      = c;
    mosi      = b;
    fifo_full = full;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(1'b0, v[i]);
  endtask

  task automatic cs_idle(input int n);
    repeat (n) send_bit(1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge write_clk);
    reset = 1'b1; cs_n = 1'b1; mosi = 1'b0; fifo_full = 1'b0;
    repeat (2) @(negedge write_clk);
    reset = 1'b0;
  endtask

  // Sends a whole frame (sync byte, payload, one trailing edge) and then
  // deselects.
  task automatic good_frame(input logic [7:0] payload);
    send_byte(8'hA5);
    send_byte(payload);
    send_bit(1'b0, 1'b0);
    cs_idle(2);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {fifo_din, fifo_write_en, frame_start, frame_done, frame_count,
                frame_err, overflow}, '0);
  endtask

  initial begin
    // Watchdog: the run must end on its own even if the DUT locks up.
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- test 1: reset state and reset in the middle of a word
    repeat (2) @(posedge write_clk);
    #1 check_all_zero("t1_por_outputs");
    @(negedge write_clk);
    reset = 1'b0;
    mark();
    send_byte(8'hA5);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    // The word-completing bit arrives together with reset, so no strobe.
    @(negedge write_clk);
    reset = 1'b1; mosi = 1'b1;
    repeat (2) @(posedge write_clk);
    #1 check_all_zero("t1_mid_reset_outputs");
    @(negedge write_clk);
    reset = 1'b0; cs_n = 1'b1;
    cs_idle(3);
    check("t1_no_stray_strobe", 32'(n_strobe - b_strobe), 0);
    // A clean frame right after reset shows the FSM restarted from IDLE.
    good_frame(8'h5C);
    check("t1_recover_strobes", 32'(n_strobe - b_strobe), 2);
    check("t1_recover_w0", word_at(b_q), 32'h5);
    check("t1_recover_w1", word_at(b_q + 1), 32'hC);

    // ---------------- test 2: nominal frame
    do_reset();
    mark();
    send_byte(8'hA5);
    @(posedge write_clk);
    #1 check("t2_frame_start_timing", 32'(frame_start), 1);
    send_byte(8'b1011_0010);
    send_bit(1'b0, 1'b0);
    cs_idle(2);
    check("t2_strobes", 32'(n_strobe - b_strobe), 2);
    check("t2_w0", word_at(b_q), 32'hB);
    check("t2_w1", word_at(b_q + 1), 32'h2);
    check("t2_starts", 32'(n_start - b_start), 1);
    check("t2_dones", 32'(n_done - b_done), 1);
    check("t2_done_with_strobe", 32'(n_done_alone - b_alone), 0);
    check("t2_frame_count", 32'(frame_count), 1);
    check("t2_errs", {30'b0, frame_err, overflow}, 0);

    // ---------------- test 3: bad sync byte, then a good frame
    do_reset();
    mark();
    send_byte(8'h5A);
    send_byte(8'b1011_0010);
    cs_idle(2);
    check("t3_bad_no_strobes", 32'(n_strobe - b_strobe), 0);
    check("t3_frame_err_set", 32'(frame_err), 1);
    good_frame(8'b1011_0010);
    check("t3_good_strobes", 32'(n_strobe - b_strobe), 2);
    check("t3_w0", word_at(b_q), 32'hB);
    check("t3_w1", word_at(b_q + 1), 32'h2);
    check("t3_frame_count", 32'(frame_count), 1);
    check("t3_frame_err_sticky", 32'(frame_err), 1);

    // ---------------- test 4: fifo_full while the second word completes
    do_reset();
    mark();
    send_byte(8'hA5);
    send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0, 1'b1);
    send_bit(1'b0, 1'b0, 1'b0);
    cs_idle(2);
    check("t4_strobes", 32'(n_strobe - b_strobe), 1);
    check("t4_w0", word_at(b_q), 32'hB);
    check("t4_overflow", 32'(overflow), 1);
    check("t4_dones", 32'(n_done - b_done), 1);
    check("t4_done_without_strobe", 32'(n_done_alone - b_alone), 1);
    check("t4_frame_count", 32'(frame_count), 1);
    check("t4_frame_err", 32'(frame_err), 0);

    // ---------------- test 5: frame cut by cs_n, then a fresh frame
    do_reset();
    mark();
    send_byte(8'hA5);
    send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    cs_idle(2);
    check("t5_cut_strobes", 32'(n_strobe - b_strobe), 1);
    check("t5_cut_w0", word_at(b_q), 32'hB);
    check("t5_frame_err", 32'(frame_err), 1);
    check("t5_no_done", 32'(n_done - b_done), 0);
    good_frame(8'b0110_1001);
    check("t5_next_strobes", 32'(n_strobe - b_strobe), 3);
    check("t5_next_w0", word_at(b_q + 1), 32'h6);
    check("t5_next_w1", word_at(b_q + 2), 32'h9);
    check("t5_frame_count", 32'(frame_count), 1);

    // ---------------- test 6: 256 back-to-back frames in one selection
    do_reset();
    mark();
    for (int i = 0; i < 256; i++) begin
      send_byte(8'hA5);
      send_byte(8'(i));
    end
    send_bit(1'b0, 1'b0);
    cs_idle(2);
    check("t6_strobes", 32'(n_strobe - b_strobe), 512);
    check("t6_dones", 32'(n_done - b_done), 256);
    check("t6_starts", 32'(n_start - b_start), 256);
    check("t6_frame_count_wrap", 32'(frame_count), 0);
    check("t6_errs", {30'b0, frame_err, overflow}, 0);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] pb;
      pb = 8'(i);
      check($sformatf("t6_f%0d_hi", i), word_at(b_q + 2 * i),     32'(pb[7:4]));
      check($sformatf("t6_f%0d_lo", i), word_at(b_q + 2 * i + 1), 32'(pb[3:0]));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
